io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_map_pkg.sv | 11 +
 rtl/io_responder_debounce.sv | 39 +++
 rtl/io_responder.sv | 59 +++++
 tb/tb_io_responder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: register addresses, STATUS bit positions and debounce default shared by the IO responder.
package io_map_pkg;
    localparam int DEBOUNCE_DEFAULT = 50000;
    localparam logic [14:0] ADDR_SW     = 15'h6000;
    localparam logic [14:0] ADDR_LED    = 15'h6001;
    localparam logic [14:0] ADDR_STATUS = 15'h6002;
    localparam logic [14:0] ADDR_WCOUNT = 15'h6003;
    localparam logic [12:0] IO_PAGE     = 13'h1800;
    localparam int BTN_PEND_BIT = 0;
    localparam int SW_CHG_BIT   = 1;
endpackage

// File: rtl/io_responder_debounce.sv
// debounce: two-flop synchronizer followed by a stable-count debouncer, any width.
module debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] rise,
    output logic             change
);
    logic [WIDTH-1:0] meta, sync, cand;
    logic [15:0] cnt;
    logic settled;
    assign settled = (sync == cand) && (cnt == 16'(CYCLES - 1));
    // change pulses in the cycle whose edge copies the candidate into value
    assign change = settled && (cand != value);
    assign rise = change ? (cand & ~value) : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta  <= '0;
            sync  <= '0;
            cand  <= '0;
            cnt   <= '0;
            value <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync != cand) begin
                cand <= sync;
                cnt  <= '0;
            end else if (!settled) begin
                cnt <= cnt + 16'd1;
            end
            if (change) value <= cand;
        end
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped switches, button, LED and write-count registers at 0x6000..0x6003.
module io_responder
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    input  logic [15:0] switches,
    input  logic        button,
    output logic        io_sel,
    output logic [15:0] io_rdata,
    output logic [15:0] led_output
);
    logic [15:0] sw_db, sw_rise, wcount;
    logic [0:0]  btn_db, btn_rise;
    logic        sw_change, btn_change, btn_pend, sw_chg, wr_led, wr_stat;

    debounce #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk(clk), .reset(reset), .raw(switches),
        .value(sw_db), .rise(sw_rise), .change(sw_change)
    );
    debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(clk), .reset(reset), .raw(button),
        .value(btn_db), .rise(btn_rise), .change(btn_change)
    );

    assign io_sel  = addressM[14:2] == IO_PAGE;
    assign wr_led  = writeM && addressM == ADDR_LED;
    assign wr_stat = writeM && addressM == ADDR_STATUS;

    always_comb begin
        io_rdata = !io_sel                 ? 16'h0000 :
                   addressM == ADDR_SW     ? sw_db :
                   addressM == ADDR_LED    ? led_output :
                   addressM == ADDR_STATUS ? {14'd0, sw_chg, btn_pend} :
                                             wcount;
    end

    // set terms are OR-ed after the clear so a same-cycle event wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_output <= '0;
            wcount     <= '0;
            btn_pend   <= 1'b0;
            sw_chg     <= 1'b0;
        end else begin
            if (wr_led) begin
                led_output <= outM;
                wcount     <= wcount + 16'd1;
            end
            btn_pend <= btn_rise[0] | (btn_pend & ~(wr_stat & outM[BTN_PEND_BIT]));
            sw_chg   <= sw_change | (sw_chg & ~(wr_stat & outM[SW_CHG_BIT]));
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed checks of register map, debounce timing, sticky flags and reset.
module tb_io_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] addressM = '0;
    logic [15:0] outM = '0;
    logic        writeM = 1'b0;
    logic [15:0] switches = '0;
    logic        button = 1'b0;
    logic        io_sel;
    logic [15:0] io_rdata, led_output;
    int tests = 0, fails = 0;

    io_responder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
        .switches(switches), .button(button), .io_sel(io_sel), .io_rdata(io_rdata),
        .led_output(led_output)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [14:0] a, input string tag, input logic [15:0] exp);
        addressM = a;
        writeM = 1'b0;
        #1;
        check(tag, io_rdata, exp);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM = d;
        writeM = 1'b1;
        tick();
        writeM = 1'b0;
    endtask

    initial begin
        #2;
        check("led_in_reset", led_output, 16'h0000);
        tick(2);
        reset = 1'b1;
        tick();
        rd(15'h6000, "rst_sw", 16'h0000);
        check("io_sel_6000", {15'd0, io_sel}, 16'h0001);
        rd(15'h6001, "rst_led", 16'h0000);
        rd(15'h6002, "rst_status", 16'h0000);
        rd(15'h6003, "rst_wcount", 16'h0000);
        check("io_sel_6003", {15'd0, io_sel}, 16'h0001);
        rd(15'h6004, "unmapped_rd", 16'h0000);
        check("io_sel_6004", {15'd0, io_sel}, 16'h0000);
        rd(15'h5FFF, "below_rd", 16'h0000);
        check("io_sel_5fff", {15'd0, io_sel}, 16'h0000);
        check("rst_led_out", led_output, 16'h0000);

        wr(15'h6001, 16'hA5A5);
        check("led_write", led_output, 16'hA5A5);
        rd(15'h6001, "led_read", 16'hA5A5);
        rd(15'h6003, "wcount_1", 16'h0001);

        wr(15'h6000, 16'h1234);
        wr(15'h6003, 16'h5555);
        wr(15'h6005, 16'h7777);
        wr(15'h2001, 16'h7777);
        check("ignored_led", led_output, 16'hA5A5);
        rd(15'h6003, "ignored_wcount", 16'h0001);
        rd(15'h6000, "ignored_sw", 16'h0000);

        addressM = 15'h6001;
        outM = 16'h1357;
        writeM = 1'b1;
        tick(65534);
        writeM = 1'b0;
        rd(15'h6003, "wcount_ffff", 16'hFFFF);
        wr(15'h6001, 16'h2468);
        rd(15'h6003, "wcount_wrap", 16'h0000);
        check("led_after_wrap", led_output, 16'h2468);

        switches = 16'h00F0;
        tick(5);
        rd(15'h6000, "sw_not_early", 16'h0000);
        tick(2);
        rd(15'h6000, "sw_debounced", 16'h00F0);
        rd(15'h6002, "status_swchg", 16'h0002);

        switches = 16'hFFFF;
        tick(3);
        switches = 16'h00F0;
        tick(10);
        rd(15'h6000, "sw_glitch", 16'h00F0);
        rd(15'h6002, "status_glitch", 16'h0002);

        button = 1'b1;
        tick(10);
        button = 1'b0;
        rd(15'h6002, "btn_pend", 16'h0003);
        tick(10);
        rd(15'h6002, "btn_sticky", 16'h0003);
        wr(15'h6002, 16'h0000);
        rd(15'h6002, "w0_no_clear", 16'h0003);
        wr(15'h6002, 16'h0001);
        rd(15'h6002, "btn_clear", 16'h0002);

        button = 1'b1;
        tick(6);
        rd(15'h6002, "btn_not_yet", 16'h0002);
        wr(15'h6002, 16'h0001);
        rd(15'h6002, "set_wins", 16'h0003);
        button = 1'b0;
        tick(10);
        wr(15'h6002, 16'h0003);
        rd(15'h6002, "clear_both", 16'h0000);
        rd(15'h6000, "sw_after_clear", 16'h00F0);

        switches = 16'h0F0F;
        tick(2);
        reset = 1'b0;
        #1;
        check("async_rst_led", led_output, 16'h0000);
        switches = 16'h0000;
        tick();
        reset = 1'b1;
        tick(10);
        rd(15'h6000, "rst_mid_sw", 16'h0000);
        rd(15'h6002, "rst_mid_status", 16'h0000);
        rd(15'h6003, "rst_mid_wcount", 16'h0000);
        switches = 16'h0F0F;
        tick(7);
        rd(15'h6000, "sw_after_rst", 16'h0F0F);
        rd(15'h6002, "status_after_rst", 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
